keypad_scanner: RTL and testbench

Scans a 4x4 matrix keypad and produces the debounced key code and a pressed flag. These are the keypad_pressed/key[4:0] signals that the top-level game state machine consumes for power toggle and screen transitions. It drives the column lines one at a time, samples the synchronized row lines, and qualifies a key only after it is stable across several full scans. The block sits between the board keypad pins and the game FSM.

---
 rtl/keypad_pkg.sv | 22 ++
 rtl/keypad_sync.sv | 15 +
 rtl/keypad_scanner.sv | 124 ++++++++++++
 tb/tb_keypad_scanner.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared keypad constants, scan states and key-code mapping
package keypad_pkg;

  localparam logic [4:0] KEY_NONE  = 5'd0;
  localparam logic [4:0] KEY_PWR   = 5'd1;
  localparam logic [4:0] KEY_SEL   = 5'd11;
  localparam logic [4:0] KEY_START = 5'd13;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic {
    ST_DRIVE,
    ST_EVAL
  } scan_state_t;

  // Code is 4*row + col + 1, so {row, col} read as a number plus one.
  function automatic logic [4:0] key_code(input logic [1:0] r, input logic [1:0] c);
    return {1'b0, r, c} + 5'd1;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// rtl/keypad_sync.sv - 2-flop synchronizer for the asynchronous row lines
module keypad_sync (
  input  logic       clk,
  input  logic [3:0] raw,
  output logic [3:0] synced
);

  logic [3:0] meta;

  always_ff @(posedge clk) begin
    meta   <= raw;
    synced <= meta;
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner with multi-scan debounce
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 27000,
  parameter int DEBOUNCE_SCANS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       keypad_pressed,
  output logic [4:0] key,
  output logic       key_strobe
);

  localparam int                SLOT_W     = $clog2(SCAN_DIV + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
  localparam logic [7:0]        STABLE_MAX = 8'(DEBOUNCE_SCANS);

  scan_state_t       state, state_next;
  logic [1:0]        col_idx, col_idx_next;
  logic [SLOT_W-1:0] slot, slot_next;
  logic              capture;
  logic [3:0]        row_sync;
  logic [3:0]        scan_map [NUM_COLS];
  logic [4:0]        candidate, prev_candidate;
  logic [7:0]        stable_cnt, stable_next;
  logic              commit;

  keypad_sync u_sync (
    .clk    (clk),
    .raw    (row),
    .synced (row_sync)
  );

  // col_idx is left at 3 through EVAL, so column 3 stays driven for that cycle.
  assign col = ~(4'b0001 << col_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_DRIVE;
      col_idx <= 2'd0;
      slot    <= '0;
    end else begin
      state   <= state_next;
      col_idx <= col_idx_next;
      slot    <= slot_next;
    end
  end

  always_comb begin
    state_next   = state;
    col_idx_next = col_idx;
    slot_next    = slot;
    capture      = 1'b0;
    case (state)
      ST_DRIVE: begin
        if (slot == SLOT_LAST) begin
          capture   = 1'b1;
          slot_next = '0;
          if (col_idx == 2'd3) state_next = ST_EVAL;
          else                 col_idx_next = col_idx + 2'd1;
        end else begin
          slot_next = slot + 1'b1;
        end
      end
      ST_EVAL: begin
        state_next   = ST_DRIVE;
        col_idx_next = 2'd0;
      end
      default: state_next = ST_DRIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_COLS; c++) scan_map[c] <= 4'hF;
    end else if (capture) begin
      scan_map[col_idx] <= row_sync;
    end
  end

  // Walk from the highest code down so the lowest pressed code is left standing.
  always_comb begin
    candidate = KEY_NONE;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      for (int c = NUM_COLS - 1; c >= 0; c--) begin
        if (!scan_map[c][r]) candidate = key_code(2'(r), 2'(c));
      end
    end
  end

  always_comb begin
    if (candidate == prev_candidate)
      stable_next = (stable_cnt < STABLE_MAX) ? stable_cnt + 8'd1 : stable_cnt;
    else
      stable_next = 8'd1;
  end

  assign commit = (state == ST_EVAL) && (stable_next == STABLE_MAX) && (candidate != key);

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_candidate <= KEY_NONE;
      stable_cnt     <= 8'd0;
      key            <= KEY_NONE;
      keypad_pressed <= 1'b0;
      key_strobe     <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      if (state == ST_EVAL) begin
        prev_candidate <= candidate;
        stable_cnt     <= stable_next;
        if (commit) begin
          key            <= candidate;
          keypad_pressed <= (candidate != KEY_NONE);
          key_strobe     <= (candidate != KEY_NONE);
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed and random keypad scenarios against a per-scan reference model
module tb_keypad_scanner;

  localparam int DB     = 3;
  localparam int PERIOD = 17;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        keypad_pressed;
  logic [4:0]  key;
  logic        key_strobe;

  logic [15:0] held = 16'h0;
  int          checks = 0;
  int          errors = 0;
  int          total_strobes = 0;
  int          hist[$];
  int          key_m = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(DB)) dut (
    .clk            (clk),
    .rst            (rst),
    .row            (row),
    .col            (col),
    .keypad_pressed (keypad_pressed),
    .key            (key),
    .key_strobe     (key_strobe)
  );

  always #5 clk = ~clk;

  // Physical keypad: a row reads low when a held key sits on a driven column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col[c] && held[r*4+c]) row[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest_code(input logic [15:0] keys);
    for (int i = 0; i < 16; i++) if (keys[i]) return i + 1;
    return 0;
  endfunction

  task automatic model_reset();
    hist.delete();
    key_m = 0;
  endtask

  // One full scan with a fixed key set; starts and ends just after an output-update edge.
  task automatic run_scan(input logic [15:0] keys, input bit check_col);
    int strobes;
    int cand;
    bit stable;
    int exp_strobe;
    strobes = 0;
    held = keys;
    for (int i = 1; i <= PERIOD; i++) begin
      @(negedge clk);
      if (key_strobe) strobes++;
      if (check_col && i == 4)  check("col_walk_c1", 16'(col), 16'hD);
      if (check_col && i == 8)  check("col_walk_c2", 16'(col), 16'hB);
      if (check_col && i == 12) check("col_walk_c3", 16'(col), 16'h7);
      if (check_col && i == 16) check("col_eval",    16'(col), 16'h7);
    end
    total_strobes += strobes;
    cand = lowest_code(keys);
    hist.push_back(cand);
    if (hist.size() > DB) void'(hist.pop_front());
    stable = (hist.size() == DB);
    foreach (hist[j]) if (hist[j] != cand) stable = 0;
    exp_strobe = 0;
    if (stable && cand != key_m) begin
      key_m = cand;
      exp_strobe = (cand != 0);
    end
    check("key",            16'(key),            16'(key_m));
    check("keypad_pressed", 16'(keypad_pressed), 16'(key_m != 0));
    check("strobe_count",   16'(strobes),        16'(exp_strobe));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"},     16'(col),            16'hE);
    check({tag, "_key"},     16'(key),            16'h0);
    check({tag, "_pressed"}, 16'(keypad_pressed), 16'h0);
    check({tag, "_strobe"},  16'(key_strobe),     16'h0);
  endtask

  initial begin
    logic [15:0] cur;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_reset_outputs("reset");
    run_scan(16'h0, 1'b1);

    // Steady power key held for 20 scans: one commit, one strobe.
    total_strobes = 0;
    for (int s = 0; s < 20; s++) run_scan(16'h0001, 1'b0);
    check("power_total_strobes", 16'(total_strobes), 16'd1);
    total_strobes = 0;
    for (int s = 0; s < 4; s++) run_scan(16'h0000, 1'b0);
    check("release_strobes", 16'(total_strobes), 16'd0);

    // Bounce code 11 on alternate scans, then hold it.
    for (int s = 0; s < 6; s++) run_scan((s % 2 == 0) ? 16'h0400 : 16'h0000, 1'b0);
    for (int s = 0; s < 4; s++) run_scan(16'h0400, 1'b0);
    total_strobes = 0;
    for (int s = 0; s < 4; s++) run_scan(16'h0000, 1'b0);
    check("release11_strobes", 16'(total_strobes), 16'd0);

    // Codes 11 and 13 together, then 13 alone: change without release.
    for (int s = 0; s < 4; s++) run_scan(16'h1400, 1'b0);
    for (int s = 0; s < 5; s++) begin
      run_scan(16'h1000, 1'b0);
      check("pressed_held_through_change", 16'(keypad_pressed), 16'h1);
    end
    for (int s = 0; s < 4; s++) run_scan(16'h0000, 1'b0);

    // Reset in the middle of a held press and a scan.
    for (int s = 0; s < 4; s++) run_scan(16'h0001, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_reset_outputs("midreset");
    for (int s = 0; s < 4; s++) run_scan(16'h0001, 1'b0);

    // Random key sets that stick for a few scans at a time.
    cur = 16'h0;
    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(3) == 0) begin
        case ($urandom_range(2))
          0:       cur = 16'h0;
          1:       cur = 16'h1 << $urandom_range(15);
          default: cur = (16'h1 << $urandom_range(15)) | (16'h1 << $urandom_range(15));
        endcase
      end
      run_scan(cur, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
